// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared types and helpers for the SPI receive path (and the future transmit
// path): SPI mode encoding, receiver FSM states and sample-edge selection.
// No ports (package).
// -----------------------------------------------------------------------------
package spi_pkg;

    // Mode number is the concatenation {cpol, cpha}.
    typedef enum logic [1:0] {
        MODE0 = 2'b00,
        MODE1 = 2'b01,
        MODE2 = 2'b10,
        MODE3 = 2'b11
    } spi_mode_t;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } rx_state_t;

    // Returns 1 when data is sampled on the rising SCLK edge, 0 for falling.
    // Modes 0 and 3 (cpol == cpha) sample on rising, modes 1 and 2 on falling.
    function automatic logic sample_on_rise(input spi_mode_t mode);
        logic result_s;
        case (mode)
            MODE0, MODE3: result_s = 1'b1;
            MODE1, MODE2: result_s = 1'b0;
            default:      result_s = 1'b1;
        endcase
        return result_s;
    endfunction

endpackage

// File: rtl/spi_edge_det.sv
// -----------------------------------------------------------------------------
// spi_edge_det
// Conditions the SPI pins for a clock_i-domain engine: optional 2-flop
// synchronizers (macro SPI_RX_SYNC_EN), then SCLK rise/fall and CS_n
// fall/rise single-cycle pulses. All three pins see identical delay so the
// bit alignment between SCLK and data is preserved.
//
// Ports:
//   clk        in  system clock
//   rst_n      in  synchronous active-low reset
//   sclk       in  raw SPI clock
//   miso       in  raw serial data
//   cs_n       in  raw chip select (active low)
//   sclk_rise  out SCLK rising edge seen this cycle
//   sclk_fall  out SCLK falling edge seen this cycle
//   cs_fall    out CS_n high->low seen this cycle
//   cs_rise    out CS_n low->high seen this cycle
//   miso_lvl   out data level aligned with the edge pulses
//   cs_n_lvl   out CS_n level aligned with the edge pulses
// -----------------------------------------------------------------------------
module spi_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic sclk,
    input  logic miso,
    input  logic cs_n,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic cs_fall,
    output logic cs_rise,
    output logic miso_lvl,
    output logic cs_n_lvl
);

    logic sclk_s;
    logic miso_s;
    logic cs_n_s;
    logic sclk_d_r;
    logic cs_n_d_r;

`ifdef SPI_RX_SYNC_EN
    logic [1:0] sclk_sync_r;
    logic [1:0] miso_sync_r;
    logic [1:0] cs_n_sync_r;

    // Two-flop synchronizers for the asynchronous SPI pins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sclk_sync_r <= 2'b00;
            miso_sync_r <= 2'b00;
            cs_n_sync_r <= 2'b00;
        end else begin
            sclk_sync_r <= {sclk_sync_r[0], sclk};
            miso_sync_r <= {miso_sync_r[0], miso};
            cs_n_sync_r <= {cs_n_sync_r[0], cs_n};
        end
    end

    assign sclk_s = sclk_sync_r[1];
    assign miso_s = miso_sync_r[1];
    assign cs_n_s = cs_n_sync_r[1];
`else
    assign sclk_s = sclk;
    assign miso_s = miso;
    assign cs_n_s = cs_n;
`endif

    // Previous-cycle copies for edge detection. CS_n history resets low so a
    // chip select already held low across reset is not mistaken for a new
    // frame start; a genuine high->low transition is required.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sclk_d_r <= 1'b0;
            cs_n_d_r <= 1'b0;
        end else begin
            sclk_d_r <= sclk_s;
            cs_n_d_r <= cs_n_s;
        end
    end

    assign sclk_rise = ~sclk_d_r &  sclk_s;
    assign sclk_fall =  sclk_d_r & ~sclk_s;
    assign cs_fall   =  cs_n_d_r & ~cs_n_s;
    assign cs_rise   = ~cs_n_d_r &  cs_n_s;
    assign miso_lvl  = miso_s;
    assign cs_n_lvl  = cs_n_s;

endmodule

// File: rtl/spi_rx_mode.sv
// -----------------------------------------------------------------------------
// spi_rx_mode
// SPI slave-side receiver for all four SPI modes, MSB- or LSB-first, any word
// width >= 2, back-to-back words under one chip select. Completed words are
// presented through a valid/ready output register; a word completing while
// the register is still full is dropped and flagged as overrun. A chip select
// release in the middle of a word pulses frame_err_o.
// Optional macro SPI_RX_SYNC_EN adds 2-flop pin synchronizers (+2 cycles on
// every latency, bit alignment unchanged).
//
// Parameters: WIDTH (bits per word), MSB_FIRST (1: first bit -> MSB).
// Ports:
//   clock_i     in  system clock
//   reset_i     in  synchronous active-low reset
//   en_i        in  receiver enable; low forces IDLE and clears overrun_o
//   cpol_i      in  SPI clock polarity, latched at CS_n fall
//   cpha_i      in  SPI clock phase, latched at CS_n fall
//   CS_n_i      in  chip select, active low
//   SCLK_i      in  SPI clock (oversampled)
//   MISO_i      in  serial data
//   rx_data_o   out last completed word
//   rx_valid_o  out rx_data_o holds an unconsumed word
//   rx_ready_i  in  consumer accepts when rx_valid_o & rx_ready_i
//   overrun_o   out sticky: a completed word was dropped
//   frame_err_o out one-cycle pulse: CS_n rose mid-word
//   busy_o      out receiver is in SHIFT
// -----------------------------------------------------------------------------
module spi_rx_mode
    import spi_pkg::*;
#(
    parameter int WIDTH     = 24,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             en_i,
    input  logic             cpol_i,
    input  logic             cpha_i,
    input  logic             CS_n_i,
    input  logic             SCLK_i,
    input  logic             MISO_i,
    output logic [WIDTH-1:0] rx_data_o,
    output logic             rx_valid_o,
    input  logic             rx_ready_i,
    output logic             overrun_o,
    output logic             frame_err_o,
    output logic             busy_o
);

    localparam int              CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic sclk_rise_s;
    logic sclk_fall_s;
    logic cs_fall_s;
    logic cs_rise_s;
    logic miso_s;
    logic cs_n_s;
    logic sample_s;

    rx_state_t        state_r,     state_n;
    spi_mode_t        mode_r,      mode_n;
    logic [CNT_W-1:0] cnt_r,       cnt_n;
    logic [WIDTH-1:0] shift_r,     shift_n;
    logic [WIDTH-1:0] shifted_s;
    logic [WIDTH-1:0] rx_data_r,   rx_data_n;
    logic             rx_valid_r,  rx_valid_n;
    logic             overrun_r,   overrun_n;
    logic             frame_err_r, frame_err_n;
    logic             busy_r;

    spi_edge_det u_edge_det (
        .clk       (clock_i),
        .rst_n     (reset_i),
        .sclk      (SCLK_i),
        .miso      (MISO_i),
        .cs_n      (CS_n_i),
        .sclk_rise (sclk_rise_s),
        .sclk_fall (sclk_fall_s),
        .cs_fall   (cs_fall_s),
        .cs_rise   (cs_rise_s),
        .miso_lvl  (miso_s),
        .cs_n_lvl  (cs_n_s)
    );

    // Select the sampling edge from the mode latched at frame start.
    always_comb begin
        if (sample_on_rise(mode_r)) begin
            sample_s = sclk_rise_s;
        end else begin
            sample_s = sclk_fall_s;
        end
    end

    // Shift register with the current MISO bit folded in.
    always_comb begin
        if (MSB_FIRST) begin
            shifted_s = {shift_r[WIDTH-2:0], miso_s};
        end else begin
            shifted_s = {miso_s, shift_r[WIDTH-1:1]};
        end
    end

    // Next-state, datapath and output-register logic.
    always_comb begin
        state_n     = state_r;
        mode_n      = mode_r;
        cnt_n       = cnt_r;
        shift_n     = shift_r;
        rx_data_n   = rx_data_r;
        frame_err_n = 1'b0;

        if (rx_valid_r && rx_ready_i) begin
            rx_valid_n = 1'b0;
        end else begin
            rx_valid_n = rx_valid_r;
        end

        if (!en_i) begin
            overrun_n = 1'b0;
        end else begin
            overrun_n = overrun_r;
        end

        case (state_r)
            IDLE: begin
                if (en_i && cs_fall_s) begin
                    state_n = SHIFT;
                    mode_n  = spi_mode_t'({cpol_i, cpha_i});
                    cnt_n   = {CNT_W{1'b0}};
                    shift_n = {WIDTH{1'b0}};
                end else begin
                    state_n = IDLE;
                end
            end
            SHIFT: begin
                if (!en_i) begin
                    // Disable drops the partial word silently.
                    state_n = IDLE;
                    cnt_n   = {CNT_W{1'b0}};
                    shift_n = {WIDTH{1'b0}};
                end else if (cs_n_s) begin
                    // CS_n release takes priority over a coincident sample edge.
                    state_n     = IDLE;
                    cnt_n       = {CNT_W{1'b0}};
                    shift_n     = {WIDTH{1'b0}};
                    frame_err_n = cs_rise_s && (cnt_r != {CNT_W{1'b0}});
                end else if (sample_s) begin
                    if (cnt_r == LAST_CNT) begin
                        // Word complete; stay in SHIFT for a back-to-back word.
                        cnt_n   = {CNT_W{1'b0}};
                        shift_n = {WIDTH{1'b0}};
                        if (!rx_valid_r || rx_ready_i) begin
                            rx_data_n  = shifted_s;
                            rx_valid_n = 1'b1;
                        end else begin
                            overrun_n = 1'b1;
                        end
                    end else begin
                        cnt_n   = cnt_r + CNT_ONE;
                        shift_n = shifted_s;
                    end
                end else begin
                    state_n = SHIFT;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = {CNT_W{1'b0}};
                shift_n = {WIDTH{1'b0}};
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            state_r     <= IDLE;
            mode_r      <= MODE0;
            cnt_r       <= {CNT_W{1'b0}};
            shift_r     <= {WIDTH{1'b0}};
            rx_data_r   <= {WIDTH{1'b0}};
            rx_valid_r  <= 1'b0;
            overrun_r   <= 1'b0;
            frame_err_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_n;
            mode_r      <= mode_n;
            cnt_r       <= cnt_n;
            shift_r     <= shift_n;
            rx_data_r   <= rx_data_n;
            rx_valid_r  <= rx_valid_n;
            overrun_r   <= overrun_n;
            frame_err_r <= frame_err_n;
            busy_r      <= (state_n == SHIFT);
        end
    end

    assign rx_data_o   = rx_data_r;
    assign rx_valid_o  = rx_valid_r;
    assign overrun_o   = overrun_r;
    assign frame_err_o = frame_err_r;
    assign busy_o      = busy_r;

endmodule

// File: tb/tb_spi_rx_mode.sv
// -----------------------------------------------------------------------------
// tb_spi_rx_mode
// Scoreboard bench for spi_rx_mode: a 24-bit MSB-first instance and an 8-bit
// LSB-first instance share the SPI pins; only one is enabled at a time.
// Stimulus pushes hand-computed words into per-instance queues; a negedge
// monitor pops and compares on every valid&ready handshake.
// -----------------------------------------------------------------------------
module tb_spi_rx_mode;

    localparam int HALF = 4;  // SCLK half period in clock cycles

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, en_a, en_b, cpol, cpha, cs_n, sclk, miso, ready_a, ready_b;
    logic [23:0] data_a;
    logic        valid_a, ovr_a, fe_a, busy_a;
    logic [7:0]  data_b;
    logic        valid_b, ovr_b, fe_b, busy_b;

    spi_rx_mode #(.WIDTH(24), .MSB_FIRST(1'b1)) dut (
        .clock_i(clk), .reset_i(rst_n), .en_i(en_a), .cpol_i(cpol), .cpha_i(cpha),
        .CS_n_i(cs_n), .SCLK_i(sclk), .MISO_i(miso),
        .rx_data_o(data_a), .rx_valid_o(valid_a), .rx_ready_i(ready_a),
        .overrun_o(ovr_a), .frame_err_o(fe_a), .busy_o(busy_a)
    );

    spi_rx_mode #(.WIDTH(8), .MSB_FIRST(1'b0)) dut8 (
        .clock_i(clk), .reset_i(rst_n), .en_i(en_b), .cpol_i(cpol), .cpha_i(cpha),
        .CS_n_i(cs_n), .SCLK_i(sclk), .MISO_i(miso),
        .rx_data_o(data_b), .rx_valid_o(valid_b), .rx_ready_i(ready_b),
        .overrun_o(ovr_b), .frame_err_o(fe_b), .busy_o(busy_b)
    );

    int checks   = 0;
    int failures = 0;
    int fe_cnt_a = 0;
    int fe_cnt_b = 0;
    logic fe_prev_a = 1'b0;
    logic [23:0] exp_a[$];
    logic [7:0]  exp_b[$];
    logic [23:0] e_a;
    logic [7:0]  e_b;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: compare every accepted word, track frame errors.
    always @(negedge clk) begin
        if (valid_a && ready_a) begin
            if (exp_a.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL word_a: unexpected word 0x%0h with empty queue", data_a);
            end else begin
                e_a = exp_a.pop_front();
                check("word_a", {8'h00, data_a}, {8'h00, e_a});
            end
        end
        if (valid_b && ready_b) begin
            if (exp_b.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL word_b: unexpected word 0x%0h with empty queue", data_b);
            end else begin
                e_b = exp_b.pop_front();
                check("word_b", {24'h000000, data_b}, {24'h000000, e_b});
            end
        end
        if (fe_a) begin
            fe_cnt_a++;
            check("fe_single_cycle", {31'd0, fe_prev_a}, 32'd0);
        end
        if (fe_b) fe_cnt_b++;
        fe_prev_a = fe_a;
    end

    task automatic half_period();
        repeat (HALF) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic cs_low(input logic p, input logic h);
        cpol = p;
        cpha = h;
        sclk = p;
        half_period();
        cs_n = 1'b0;
        half_period();
    endtask

    task automatic cs_high();
        half_period();
        cs_n = 1'b1;
        half_period();
        half_period();
    endtask

    // Sends bits[n-1] first; lat=1 checks rx_valid timing around the last bit.
    task automatic send_bits(input logic [47:0] bits, input int n, input logic lat);
        for (int i = 0; i < n; i++) begin
            if (!cpha) miso = bits[n-1-i];
            half_period();
            sclk = ~cpol;
            if (cpha) miso = bits[n-1-i];
            if (lat && !cpha && (i == n - 1)) begin
                @(negedge clk);
                check("lat_before", {31'd0, valid_a}, 32'd0);
                @(negedge clk);
                check("lat_valid", {31'd0, valid_a}, 32'd1);
                @(negedge clk);
                check("lat_single", {31'd0, valid_a}, 32'd0);
            end
            half_period();
            sclk = cpol;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; en_a = 1'b1; en_b = 1'b0; cpol = 1'b0; cpha = 1'b0;
        cs_n = 1'b1; sclk = 1'b0; miso = 1'b0; ready_a = 1'b1; ready_b = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        // Reset state.
        @(negedge clk);
        check("rst_data", {8'h00, data_a}, 32'd0);
        check("rst_valid", {31'd0, valid_a}, 32'd0);
        check("rst_ovr", {31'd0, ovr_a}, 32'd0);
        check("rst_fe", {31'd0, fe_a}, 32'd0);
        check("rst_busy", {31'd0, busy_a}, 32'd0);
        check("rst_valid_b", {31'd0, valid_b}, 32'd0);

        // Mode 0 with latency and busy checks.
        exp_a.push_back(24'hA5C3F0);
        cs_low(1'b0, 1'b0);
        @(negedge clk);
        check("busy_shift", {31'd0, busy_a}, 32'd1);
        send_bits(48'hA5C3F0, 24, 1'b1);
        cs_high();
        check("busy_idle", {31'd0, busy_a}, 32'd0);

        // Modes 3, 1, 2 with the same word.
        exp_a.push_back(24'hA5C3F0);
        cs_low(1'b1, 1'b1); send_bits(48'hA5C3F0, 24, 1'b0); cs_high();
        exp_a.push_back(24'hA5C3F0);
        cs_low(1'b0, 1'b1); send_bits(48'hA5C3F0, 24, 1'b0); cs_high();
        exp_a.push_back(24'h5A3C0F);
        cs_low(1'b1, 1'b0); send_bits(48'h5A3C0F, 24, 1'b0); cs_high();

        // LSB-first 8-bit instance: stream 1,0..0 -> 0x01; then 0xA6 (stream 0x65).
        en_a = 1'b0; en_b = 1'b1;
        exp_b.push_back(8'h01);
        exp_b.push_back(8'hA6);
        cs_low(1'b0, 1'b0); send_bits({32'd0, 8'h80, 8'h65}, 16, 1'b0); cs_high();
        en_b = 1'b0; en_a = 1'b1;

        // Back-to-back words with consumer stalled -> overrun.
        ready_a = 1'b0;
        cs_low(1'b0, 1'b0); send_bits({24'h111111, 24'h222222}, 48, 1'b0); cs_high();
        @(negedge clk);
        check("ovr_data", {8'h00, data_a}, 32'h00111111);
        check("ovr_valid", {31'd0, valid_a}, 32'd1);
        check("ovr_flag", {31'd0, ovr_a}, 32'd1);
        exp_a.push_back(24'h111111);
        ready_a = 1'b1;
        repeat (2) @(negedge clk);
        check("ovr_drain_valid", {31'd0, valid_a}, 32'd0);
        check("ovr_sticky", {31'd0, ovr_a}, 32'd1);
        @(posedge clk); #2 en_a = 1'b0;
        @(posedge clk); #2 en_a = 1'b1;
        @(negedge clk);
        check("ovr_clear_en", {31'd0, ovr_a}, 32'd0);

        // Frame error after 10 bits, then a clean frame held unconsumed.
        cs_low(1'b0, 1'b0); send_bits(48'h2AB, 10, 1'b0); cs_high();
        check("fe_count", fe_cnt_a, 32'd1);
        check("fe_no_valid", {31'd0, valid_a}, 32'd0);
        ready_a = 1'b0;
        cs_low(1'b0, 1'b0); send_bits(48'h0F0F0F, 24, 1'b0); cs_high();
        check("after_fe_data", {8'h00, data_a}, 32'h000F0F0F);
        check("after_fe_valid", {31'd0, valid_a}, 32'd1);

        // Reset pulse mid-word clears everything.
        cs_low(1'b0, 1'b0); send_bits(48'h15, 5, 1'b0);
        @(posedge clk); #2 rst_n = 1'b0;
        @(posedge clk); #2 rst_n = 1'b1;
        @(negedge clk);
        check("mrst_data", {8'h00, data_a}, 32'd0);
        check("mrst_valid", {31'd0, valid_a}, 32'd0);
        check("mrst_busy", {31'd0, busy_a}, 32'd0);
        check("mrst_ovr", {31'd0, ovr_a}, 32'd0);
        ready_a = 1'b1;
        cs_high();
        exp_a.push_back(24'h123456);
        cs_low(1'b0, 1'b0); send_bits(48'h123456, 24, 1'b0); cs_high();

        repeat (10) @(negedge clk);
        check("fe_total_a", fe_cnt_a, 32'd1);
        check("fe_total_b", fe_cnt_b, 32'd0);
        check("queue_a_empty", exp_a.size(), 32'd0);
        check("queue_b_empty", exp_b.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
